// File: rtl/pool_bus_arbiter_pkg.sv
// Shared types and defaults for the pool-unit bus arbiter.
// Holds the FSM state encoding, the owner tag and the grant decode helpers.
package pool_bus_pkg;

  localparam int unsigned POOL_ID_W  = 4;
  localparam int unsigned POOL_LEN_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4,
    ABORT   = 3'd5
  } arb_state_t;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } owner_t;

  function automatic logic is_read_state(input arb_state_t s);
    return (s == RD_ADDR) || (s == RD_DATA);
  endfunction

  function automatic logic is_write_state(input arb_state_t s);
    return (s == WR_ADDR) || (s == WR_DATA);
  endfunction

endpackage

// File: rtl/pool_bus_arbiter_if.sv
// Request, bus-handshake and grant signals between the pool bridges and the arbiter.
// The arbiter uses the slave view; whoever drives the bridges and bus uses the master view.
interface pool_bus_arbiter_if
  import pool_bus_pkg::*;
#(
  parameter int unsigned ID_W  = POOL_ID_W,
  parameter int unsigned LEN_W = POOL_LEN_W
);
  logic             rd_req;
  logic [ID_W-1:0]  rd_id;
  logic [LEN_W-1:0] rd_len;
  logic             wr_req;
  logic [ID_W-1:0]  wr_id;
  logic [LEN_W-1:0] wr_len;
  logic             arready;
  logic             rvalid;
  logic             rlast;
  logic [ID_W-1:0]  rid;
  logic             awready;
  logic             wready;
  logic             wuser_last;
  logic [ID_W-1:0]  wuser_id;
  logic             err_clr;
  logic             link_read;
  logic             link_write;
  logic             busy;
  logic             timeout_err;
  logic             err_flag;

  modport slave (
    input  rd_req, rd_id, rd_len, wr_req, wr_id, wr_len,
    input  arready, rvalid, rlast, rid,
    input  awready, wready, wuser_last, wuser_id, err_clr,
    output link_read, link_write, busy, timeout_err, err_flag
  );

  modport master (
    output rd_req, rd_id, rd_len, wr_req, wr_id, wr_len,
    output arready, rvalid, rlast, rid,
    output awready, wready, wuser_last, wuser_id, err_clr,
    input  link_read, link_write, busy, timeout_err, err_flag
  );
endinterface

// File: rtl/pool_bus_arbiter_watchdog.sv
// Stall watchdog: counts cycles without progress while a transfer owns the bus.
// expire is raised on the TIMEOUT_CYC-th consecutive stalled cycle; a kick in that cycle wins.
module pool_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic kick,
  output logic expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 32'd1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Expiry decode and next stall count.
  always_comb begin
    expire = run && !kick && (cnt_q == LIMIT);
    if (!run || kick || expire) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pool_bus_arbiter.sv
// Round-robin owner of the shared pool-unit bus: grants the read or write bridge
// from its address handshake to its last data beat, with a watchdog abort on stalls.
module pool_bus_arbiter
  import pool_bus_pkg::*;
#(
  parameter int unsigned ID_W        = POOL_ID_W,
  parameter int unsigned LEN_W       = POOL_LEN_W,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  pool_bus_arbiter_if.slave bus
);

  arb_state_t       state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic             link_read_q, link_read_d;
  logic             link_write_q, link_write_d;
  logic             busy_q, busy_d;
  logic             timeout_err_q, timeout_err_d;
  logic             err_flag_q, err_flag_d;

  logic rd_beat_s;
  logic wr_beat_s;
  logic run_s;
  logic kick_s;
  logic expire_s;

  // Progress qualification: only beats tagged with the owner's id count.
  always_comb begin
    rd_beat_s = bus.rvalid && (bus.rid == id_q);
    wr_beat_s = bus.wready && (bus.wuser_id == id_q);
    run_s     = (state_q != IDLE) && (state_q != ABORT);
    kick_s    = ((state_q == RD_ADDR) && bus.rd_req && bus.arready) ||
                ((state_q == RD_DATA) && rd_beat_s) ||
                ((state_q == WR_ADDR) && bus.wr_req && bus.awready) ||
                ((state_q == WR_DATA) && wr_beat_s);
  end

  pool_arb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run_s),
    .kick   (kick_s),
    .expire (expire_s)
  );

  // Next-state, ownership history and burst bookkeeping.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    id_d    = id_q;
    len_d   = len_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        // A tie goes to the side that did not own the bus last.
        if (bus.rd_req && (!bus.wr_req || (owner_q == WR))) begin
          state_d = RD_ADDR;
          id_d    = bus.rd_id;
          len_d   = bus.rd_len;
        end else if (bus.wr_req) begin
          state_d = WR_ADDR;
          id_d    = bus.wr_id;
          len_d   = bus.wr_len;
        end else begin
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (!bus.rd_req) begin
          state_d = IDLE;
        end else if (bus.arready) begin
          state_d = RD_DATA;
          beat_d  = '0;
        end else if (expire_s) begin
          state_d = ABORT;
          owner_d = RD;
        end else begin
          state_d = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (rd_beat_s) begin
          if (bus.rlast || (beat_q == len_q)) begin
            state_d = IDLE;
            owner_d = RD;
          end else begin
            beat_d = beat_q + LEN_W'(1'b1);
          end
        end else if (expire_s) begin
          state_d = ABORT;
          owner_d = RD;
        end else begin
          state_d = RD_DATA;
        end
      end
      WR_ADDR: begin
        if (!bus.wr_req) begin
          state_d = IDLE;
        end else if (bus.awready) begin
          state_d = WR_DATA;
          beat_d  = '0;
        end else if (expire_s) begin
          state_d = ABORT;
          owner_d = WR;
        end else begin
          state_d = WR_ADDR;
        end
      end
      WR_DATA: begin
        if (wr_beat_s) begin
          if (bus.wuser_last || (beat_q == len_q)) begin
            state_d = IDLE;
            owner_d = WR;
          end else begin
            beat_d = beat_q + LEN_W'(1'b1);
          end
        end else if (expire_s) begin
          state_d = ABORT;
          owner_d = WR;
        end else begin
          state_d = WR_DATA;
        end
      end
      ABORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so grants switch on the same edge as the FSM.
  always_comb begin
    link_read_d   = is_read_state(state_d);
    link_write_d  = is_write_state(state_d);
    busy_d        = link_read_d | link_write_d;
    timeout_err_d = (state_d == ABORT);
    if (state_d == ABORT) begin
      err_flag_d = 1'b1;
    end else if (bus.err_clr) begin
      err_flag_d = 1'b0;
    end else begin
      err_flag_d = err_flag_q;
    end
  end

  // State and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= WR;
      id_q          <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      link_read_q   <= 1'b0;
      link_write_q  <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      err_flag_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      id_q          <= id_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      link_read_q   <= link_read_d;
      link_write_q  <= link_write_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      err_flag_q    <= err_flag_d;
    end
  end

  assign bus.link_read   = link_read_q;
  assign bus.link_write  = link_write_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.err_flag    = err_flag_q;

endmodule

// File: tb/tb_pool_bus_arbiter.sv
// Bench for pool_bus_arbiter: directed vector table, hand-written corner sequences,
// then random traffic compared against a transaction-level model of the arbitration rules.
module tb_pool_bus_arbiter;

  localparam int TMO = 8;

  typedef struct packed {
    logic       rd_req;
    logic [3:0] rd_id;
    logic [3:0] rd_len;
    logic       wr_req;
    logic [3:0] wr_id;
    logic [3:0] wr_len;
    logic       arready;
    logic       rvalid;
    logic       rlast;
    logic [3:0] rid;
    logic       awready;
    logic       wready;
    logic       wlast;
    logic [3:0] wid;
    logic       clr;
    logic [4:0] exp;   // {link_read, link_write, busy, timeout_err, err_flag}
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t cur;
  vec_t tbl [25];

  // Model state: owner 0 none / 1 read / 2 write; last 1 read / 2 write.
  int         m_own;
  int         m_last;
  int         m_left;
  int         m_stall;
  bit         m_addr;
  bit         m_abort;
  bit         m_err;
  logic [3:0] m_id;

  pool_bus_arbiter_if #(.ID_W(4), .LEN_W(4)) bus_if ();

  pool_bus_arbiter #(
    .ID_W        (4),
    .LEN_W       (4),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int rq, input int ri, input int rl, input int wq,
                              input int wi, input int wl, input int ar, input int rv,
                              input int rla, input int rd, input int aw, input int wv,
                              input int wla, input int wd, input int cl, input int e);
    vec_t v;
    v.rd_req = rq[0]; v.rd_id = 4'(ri); v.rd_len = 4'(rl);
    v.wr_req = wq[0]; v.wr_id = 4'(wi); v.wr_len = 4'(wl);
    v.arready = ar[0]; v.rvalid = rv[0]; v.rlast = rla[0]; v.rid = 4'(rd);
    v.awready = aw[0]; v.wready = wv[0]; v.wlast = wla[0]; v.wid = 4'(wd);
    v.clr = cl[0]; v.exp = 5'(e);
    return v;
  endfunction

  task automatic tick();
    bus_if.rd_req = cur.rd_req;   bus_if.rd_id = cur.rd_id;   bus_if.rd_len = cur.rd_len;
    bus_if.wr_req = cur.wr_req;   bus_if.wr_id = cur.wr_id;   bus_if.wr_len = cur.wr_len;
    bus_if.arready = cur.arready; bus_if.rvalid = cur.rvalid; bus_if.rlast = cur.rlast;
    bus_if.rid = cur.rid;         bus_if.awready = cur.awready;
    bus_if.wready = cur.wready;   bus_if.wuser_last = cur.wlast;
    bus_if.wuser_id = cur.wid;    bus_if.err_clr = cur.clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {bus_if.link_read, bus_if.link_write, bus_if.busy, bus_if.timeout_err, bus_if.err_flag};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (lr lw busy to err)", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_last = 2; m_left = 0; m_stall = 0;
    m_addr = 1'b0; m_abort = 1'b0; m_err = 1'b0; m_id = 4'd0;
  endtask

  // Advance the model by one cycle using the inputs in cur.
  task automatic model_step();
    bit ab, prog, fin, drop;
    ab = 1'b0; prog = 1'b0; fin = 1'b0; drop = 1'b0;
    if (m_abort) begin
      m_abort = 1'b0;
    end else if (m_own == 0) begin
      if (cur.rd_req && (!cur.wr_req || m_last == 2)) begin
        m_own = 1; m_id = cur.rd_id; m_left = int'(cur.rd_len) + 1; m_addr = 1'b0; m_stall = 0;
      end else if (cur.wr_req) begin
        m_own = 2; m_id = cur.wr_id; m_left = int'(cur.wr_len) + 1; m_addr = 1'b0; m_stall = 0;
      end
    end else begin
      if (m_own == 1) begin
        if (!m_addr) begin
          if (!cur.rd_req) drop = 1'b1;
          else if (cur.arready) begin m_addr = 1'b1; prog = 1'b1; end
        end else if (cur.rvalid && cur.rid == m_id) begin
          prog = 1'b1; m_left--; fin = cur.rlast || (m_left == 0);
        end
      end else begin
        if (!m_addr) begin
          if (!cur.wr_req) drop = 1'b1;
          else if (cur.awready) begin m_addr = 1'b1; prog = 1'b1; end
        end else if (cur.wready && cur.wid == m_id) begin
          prog = 1'b1; m_left--; fin = cur.wlast || (m_left == 0);
        end
      end
      if (drop) m_own = 0;
      else if (fin) begin m_last = m_own; m_own = 0; end
      else if (prog) m_stall = 0;
      else begin
        m_stall++;
        if (m_stall == TMO) begin m_last = m_own; m_own = 0; m_abort = 1'b1; ab = 1'b1; end
      end
    end
    m_err = ab ? 1'b1 : (cur.clr ? 1'b0 : m_err);
  endtask

  task automatic run_wr_timeout(input logic clr);
    cur = '0; cur.wr_req = 1'b1; cur.wr_id = 4'd1; cur.clr = clr;
    tick(); check("to_grant", 5'b01100);
    for (int k = 1; k < TMO; k++) begin
      tick(); check($sformatf("to_stall%0d", k), 5'b01100);
    end
    tick(); check("to_abort", 5'b00011);
    cur.wr_req = 1'b0;
    tick(); check("to_after", {4'b0000, ~clr});
  endtask

  initial begin
    logic [4:0] e;
    bit quiet;
    checks = 0; errors = 0;
    cur = '0;
    model_reset();
    rst_n = 1'b0;
    tick(); tick();
    check("reset", 5'b00000);
    rst_n = 1'b1;
    tick();
    check("reset_idle", 5'b00000);

    //               rq id ln  wq id ln  ar rv rl rid aw wv wl wid clr exp
    tbl[0]  = mk(1, 1, 0,  1, 2, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 'b10100);
    tbl[1]  = mk(1, 1, 0,  1, 2, 0,  1, 0, 0, 0,  0, 0, 0, 0,  0, 'b10100);
    tbl[2]  = mk(0, 0, 0,  1, 2, 0,  0, 1, 0, 1,  0, 0, 0, 0,  0, 'b00000);
    tbl[3]  = mk(1, 3, 3,  1, 2, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 'b01100);
    tbl[4]  = mk(1, 3, 3,  1, 2, 0,  0, 0, 0, 0,  1, 0, 0, 0,  0, 'b01100);
    tbl[5]  = mk(1, 3, 3,  0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 2,  0, 'b00000);
    tbl[6]  = mk(1, 3, 3,  1, 2, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 'b10100);
    tbl[7]  = mk(1, 3, 3,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 'b10100);
    tbl[8]  = mk(1, 3, 3,  0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0,  0, 'b10100);
    tbl[9]  = mk(0, 0, 0,  0, 0, 0,  0, 1, 0, 3,  0, 0, 0, 0,  0, 'b10100);
    tbl[10] = mk(0, 0, 0,  0, 0, 0,  0, 1, 0, 3,  0, 0, 0, 0,  0, 'b10100);
    tbl[11] = mk(0, 0, 0,  0, 0, 0,  0, 1, 0, 3,  0, 0, 0, 0,  0, 'b10100);
    tbl[12] = mk(0, 0, 0,  0, 0, 0,  0, 1, 1, 3,  0, 0, 0, 0,  0, 'b00000);
    tbl[13] = mk(1, 5, 1,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 'b10100);
    tbl[14] = mk(1, 5, 1,  0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0,  0, 'b10100);
    tbl[15] = mk(0, 0, 0,  0, 0, 0,  0, 1, 0, 5,  0, 0, 0, 0,  0, 'b10100);
    tbl[16] = mk(0, 0, 0,  0, 0, 0,  0, 1, 0, 2,  0, 0, 0, 0,  0, 'b10100);
    tbl[17] = mk(0, 0, 0,  0, 0, 0,  0, 1, 0, 5,  0, 0, 0, 0,  0, 'b00000);
    tbl[18] = mk(0, 0, 0,  1, 4, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 'b01100);
    tbl[19] = mk(0, 0, 0,  1, 4, 0,  0, 0, 0, 0,  1, 0, 0, 0,  0, 'b01100);
    tbl[20] = mk(0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 7,  0, 'b01100);
    tbl[21] = mk(0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 4,  0, 'b00000);
    tbl[22] = mk(1, 6, 3,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 'b10100);
    tbl[23] = mk(1, 6, 3,  0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0,  0, 'b10100);
    tbl[24] = mk(0, 0, 0,  0, 0, 0,  0, 1, 1, 6,  0, 0, 0, 0,  0, 'b00000);
    for (int i = 0; i < 25; i++) begin
      cur = tbl[i];
      tick();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    run_wr_timeout(1'b0);
    cur = '0;
    tick(); check("err_sticky", 5'b00001);
    cur.clr = 1'b1;
    tick(); check("err_clear", 5'b00000);
    run_wr_timeout(1'b1);

    // A valid last beat on the cycle the watchdog would expire is a normal exit.
    cur = '0; cur.rd_req = 1'b1; cur.rd_id = 4'd9; cur.rd_len = 4'd3;
    tick(); check("race_grant", 5'b10100);
    cur.arready = 1'b1;
    tick(); check("race_addr", 5'b10100);
    cur = '0;
    for (int k = 1; k < TMO; k++) begin
      tick(); check($sformatf("race_stall%0d", k), 5'b10100);
    end
    cur.rvalid = 1'b1; cur.rid = 4'd9; cur.rlast = 1'b1;
    tick(); check("race_exit", 5'b00000);

    run_wr_timeout(1'b0);
    cur = '0; cur.rd_req = 1'b1; cur.rd_id = 4'd2; cur.rd_len = 4'd3;
    tick(); check("rst_grant", 5'b10101);
    cur.arready = 1'b1;
    tick(); check("rst_addr", 5'b10101);
    cur = '0; cur.rvalid = 1'b1; cur.rid = 4'd2;
    tick(); check("rst_beat", 5'b10101);
    rst_n = 1'b0;
    #1;
    check("rst_async", 5'b00000);
    cur = '0;
    tick();
    rst_n = 1'b1;
    model_reset();
    tick(); check("rst_release", 5'b00000);

    for (int c = 0; c < 3000; c++) begin
      quiet = ((c / 40) % 4) == 3;
      cur.rd_req  = ($urandom_range(0, 3) != 0);
      cur.rd_id   = 4'($urandom_range(0, 3));
      cur.rd_len  = 4'($urandom_range(0, 3));
      cur.wr_req  = ($urandom_range(0, 3) != 0);
      cur.wr_id   = 4'($urandom_range(0, 3));
      cur.wr_len  = 4'($urandom_range(0, 3));
      cur.arready = !quiet && ($urandom_range(0, 2) == 0);
      cur.rvalid  = !quiet && ($urandom_range(0, 1) == 1);
      cur.rlast   = ($urandom_range(0, 5) == 0);
      cur.rid     = 4'($urandom_range(0, 3));
      cur.awready = !quiet && ($urandom_range(0, 2) == 0);
      cur.wready  = !quiet && ($urandom_range(0, 1) == 1);
      cur.wlast   = ($urandom_range(0, 5) == 0);
      cur.wid     = 4'($urandom_range(0, 3));
      cur.clr     = ($urandom_range(0, 19) == 0);
      model_step();
      tick();
      e = {m_own == 1, m_own == 2, m_own != 0, m_abort, m_err};
      check($sformatf("rand%0d", c), e);
      checks++;
      if (bus_if.link_read && bus_if.link_write) begin
        errors++;
        $display("FAIL excl%0d: got both grants high expected at most one", c);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_bus_arbiter.md
Name: pool_bus_arbiter

Overview:
- Sequences ownership of the shared pool-unit system bus between the pool read bridge and the pool write bridge.
- Generates the registered `link_read` / `link_write` grants that drive the pool unit's bus tri-state enables.
- Arbitrates read and write requests round-robin. A grant is held from the address handshake until the burst's last data beat.
- A watchdog reclaims the bus from a stalled transaction.

Parameters:
- ID_W, 4: width of the `rid` / `wuser_id` / `arusrid` / `awuser_id` fields.
- LEN_W, 4: burst length field width; length value = beats - 1.
- TIMEOUT_CYC, 255: idle cycles without progress before a granted transfer is aborted; 1..2^16-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  read bridge requests the bus (its `arvalid`)
- rd_id  in  ID_W  read bridge `arusrid`
- rd_len  in  LEN_W  read bridge `arlen`
- wr_req  in  1  write bridge requests the bus (its `awvalid`)
- wr_id  in  ID_W  write bridge `awuser_id`
- wr_len  in  LEN_W  write bridge `awlen`
- arready  in  1  bus read-address accept
- rvalid  in  1  bus read-data beat
- rlast  in  1  bus last read beat
- rid  in  ID_W  bus read-data ID
- awready  in  1  bus write-address accept
- wready  in  1  bus write-data beat accept
- wuser_last  in  1  bus last write beat
- wuser_id  in  ID_W  bus write-data ID
- err_clr  in  1  clears `err_flag`
- link_read  out  1  read bridge owns the bus
- link_write  out  1  write bridge owns the bus
- busy  out  1  any grant active
- timeout_err  out  1  one-cycle pulse on watchdog abort
- err_flag  out  1  sticky watchdog error

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; all outputs = 0.
  - `last_owner` = WR, so read wins the first tie.
  - Beat counter = 0; watchdog = 0.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, ABORT.
- IDLE:
  - `rd_req` only -> RD_ADDR. `wr_req` only -> WR_ADDR.
  - Both -> the side not equal to `last_owner`.
  - On entry to an ADDR state: latch the requester's id and len; `link_*` rises on the next clock edge (1-cycle grant latency).
- RD_ADDR:
  - `rd_req && arready` -> RD_DATA; beat counter = 0.
  - `rd_req` deasserted before the handshake -> IDLE; no beats; `last_owner` unchanged.
- RD_DATA:
  - A beat is `rvalid && rid == latched_id`. Beats with a mismatched rid are ignored and do not feed the watchdog.
  - Exit to IDLE on a valid beat with `rlast`, or on the beat where count == len.
  - At exit: `last_owner` = RD; `link_read` = 0 registered on that same edge.
- WR_ADDR / WR_DATA mirror the read side:
  - Handshake is `wr_req && awready`.
  - A beat is `wready && wuser_id == latched_id`; exit on `wuser_last` or count == len.
  - At exit: `last_owner` = WR.
- Mutual exclusion: `link_read && link_write` never both 1, in any cycle, including a back-to-back handover.
- Handover: at least one cycle with both grants low between owners; the IDLE visit guarantees this. Minimum burst-to-burst gap is 2 cycles.
- `busy` = `link_read | link_write`.
- Watchdog:
  - Counts in every non-IDLE state; clears on any handshake or valid beat, and on entering IDLE.
  - Reaching TIMEOUT_CYC -> ABORT.
  - ABORT (one cycle): grants low; `timeout_err` = 1; `err_flag` set; `last_owner` = aborted side; -> IDLE.
- `err_flag`:
  - `err_clr` clears it.
  - A simultaneous set and clear -> set wins.
- Widths: beat counter is LEN_W bits; the compare is to the latched len, so it cannot wrap past len. len = 0 is a single-beat burst.
- Simultaneous `rlast` and watchdog expiry on the same cycle: the valid beat wins; normal exit, no error.
- Reset asserted mid-burst: grants drop immediately (asynchronously); no error flagged.

Decomposition:
- Package `pool_bus_pkg`:
  - state enum `arb_state_t`
  - owner enum `owner_t` {RD, WR}
  - default ID_W, LEN_W constants
- Sub-module `pool_arb_watchdog`:
  - Inputs: clk, rst_n, `run`, `kick`.
  - Parameter: TIMEOUT_CYC.
  - Output: `expire` pulse.
  - Instantiated once.

Test Plan:
- Read only: `rd_req`=1, id=3, len=3; `arready` at cycle 2; 4 `rvalid` beats with rid=3, `rlast` on the 4th -> `link_read` high from cycle 1 through the last beat; low next cycle; `link_write` stays 0.
- Tie after reset: `rd_req` and `wr_req` both 1 at cycle 0 -> read granted first. After its 1-beat burst, write is granted with ≥1 cycle of both grants low. The next tie goes to read (`last_owner` = WR).
- ID filter: read id=5, len=1; beats rid=5, rid=2, rid=5 -> exit after the second rid=5 beat; the rid=2 beat is not counted.
- Timeout: TIMEOUT_CYC=8; write granted, `awready` never asserted -> ABORT at 8 stalled cycles; `timeout_err` pulse of 1 cycle; `err_flag` stays 1 until `err_clr`.
- Early count exit: write len=0, single `wready` beat with matching id and `wuser_last`=0 -> exit on that beat.
- Reset mid-burst: `rst_n` low during RD_DATA -> `link_read` 0 asynchronously; after release, state IDLE and `err_flag` 0.
